// File: rtl/legv8_pkg.sv
// Shared LEGv8 pipeline definitions.
// Holds the memory-stage FSM state encoding and the register-index width
// used by every pipeline register that carries a destination register.
package legv8_pkg;

   // Width of a register index (X0..X31)
   localparam int REG_W = 5;

   // Memory-stage bus FSM: wait for a memory op, hold the request until
   // acknowledged, then spend one cycle releasing the stall
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mem_state_t;

endpackage

// File: rtl/pipe_reg_en.sv
// Generic pipeline register with load enable.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-high reset, clears the register to 0
//   en_i   - load enable; register holds its value when low
//   d_i    - next value
//   q_o    - registered value
module pipe_reg_en #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   // Loads on enabled edges, otherwise holds; reset wins at any time
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_o <= '0;
      end else if (en_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// LEGv8 pipeline memory stage.
// Latches execute-stage results in an EX/MEM register, performs loads and
// stores over a request/acknowledge data-memory bus, resolves conditional
// branches and feeds the MEM/WB register read by writeback. It is the only
// source of pipeline stall: upstream stages freeze while a memory access is
// outstanding.
// Ports:
//   clk, reset                      - clock and asynchronous active-high reset
//   *_E                             - execute-stage valid, control and results
//   flush_E                         - squash the instruction entering from EX
//   dm_req/dm_we/dm_addr/dm_wdata   - data-memory request bus (outputs)
//   dm_rdata/dm_ack                 - data-memory response (inputs)
//   stall_M                         - freeze PC, IF/ID and ID/EX
//   PCSrc_M/PCBranch_M              - taken-branch indication and target
//   *_W                             - MEM/WB register contents
module mem_stage
   import legv8_pkg::*;
#(
   parameter int N = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_E,
   input  logic             memRead_E,
   input  logic             memWrite_E,
   input  logic             branch_E,
   input  logic             regWrite_E,
   input  logic             memtoReg_E,
   input  logic [REG_W-1:0] rd_E,
   input  logic [N-1:0]     aluResult_E,
   input  logic [N-1:0]     writeData_E,
   input  logic [N-1:0]     PCBranch_E,
   input  logic             zero_E,
   input  logic             flush_E,
   output logic             dm_req,
   output logic             dm_we,
   output logic [N-1:0]     dm_addr,
   output logic [N-1:0]     dm_wdata,
   input  logic [N-1:0]     dm_rdata,
   input  logic             dm_ack,
   output logic             stall_M,
   output logic             PCSrc_M,
   output logic [N-1:0]     PCBranch_M,
   output logic             valid_W,
   output logic             regWrite_W,
   output logic             memtoReg_W,
   output logic [REG_W-1:0] rd_W,
   output logic [N-1:0]     readData_W,
   output logic [N-1:0]     aluResult_W
);

   localparam int EXM_W   = 7 + REG_W + 3 * N;
   localparam int MEMWB_W = 3 + REG_W + 2 * N;

   logic [EXM_W-1:0]   exMem_d;
   logic [EXM_W-1:0]   exMem_q;
   logic [MEMWB_W-1:0] memWb_d;
   logic [MEMWB_W-1:0] memWb_q;
   logic [N-1:0]       rdata_q;
   logic               rdataEn;
   logic               advance;

   logic               valid_M;
   logic               memRead_M;
   logic               memWrite_M;
   logic               branch_M;
   logic               regWrite_M;
   logic               memtoReg_M;
   logic               zero_M;
   logic [REG_W-1:0]   rd_M;
   logic [N-1:0]       aluResult_M;
   logic [N-1:0]       writeData_M;
   logic [N-1:0]       PCBranch_M_q;
   logic               memop_M;
   logic [N-1:0]       loadData;

   mem_state_t         state_q;
   mem_state_t         state_d;

   // Both pipeline registers advance together whenever no access is pending
   assign advance = ~stall_M;

   // A squashed instruction enters M as a bubble, keeping its other fields
   assign exMem_d = {valid_E & ~flush_E, memRead_E, memWrite_E, branch_E,
                     regWrite_E, memtoReg_E, zero_E, rd_E,
                     aluResult_E, writeData_E, PCBranch_E};

   pipe_reg_en #(.W(EXM_W)) uExMem (
      .clk   (clk),
      .reset (reset),
      .en_i  (advance),
      .d_i   (exMem_d),
      .q_o   (exMem_q)
   );

   assign {valid_M, memRead_M, memWrite_M, branch_M, regWrite_M, memtoReg_M,
           zero_M, rd_M, aluResult_M, writeData_M, PCBranch_M_q} = exMem_q;

   assign memop_M = valid_M & (memRead_M | memWrite_M);

   // Bus fields come straight from EX/MEM, so they stay put while stalled
   assign dm_addr  = aluResult_M;
   assign dm_wdata = writeData_M;
   assign dm_we    = memWrite_M;

   // The stall is released in DONE so that the edge leaving DONE both
   // retires the memory op into MEM/WB and admits the next instruction
   assign stall_M = memop_M & (state_q != DONE);

   assign PCSrc_M    = valid_M & branch_M & zero_M;
   assign PCBranch_M = PCBranch_M_q;

   // FSM state register; reset abandons any in-flight transaction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state and request; dm_ack only matters while requesting
   always_comb begin
      state_d = state_q;
      dm_req  = 1'b0;
      case (state_q)
         IDLE: begin
            if (memop_M) begin
               state_d = REQ;
            end
         end
         REQ: begin
            dm_req = 1'b1;
            if (dm_ack) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Load data is captured on the acknowledging edge and held for DONE
   assign rdataEn = (state_q == REQ) & dm_ack;

   pipe_reg_en #(.W(N)) uRdata (
      .clk   (clk),
      .reset (reset),
      .en_i  (rdataEn),
      .d_i   (dm_rdata),
      .q_o   (rdata_q)
   );

   // An access with both read and write set behaves as a store: no data
   assign loadData = (memRead_M & ~memWrite_M) ? rdata_q : '0;

   assign memWb_d = {valid_M, regWrite_M, memtoReg_M, rd_M, loadData, aluResult_M};

   pipe_reg_en #(.W(MEMWB_W)) uMemWb (
      .clk   (clk),
      .reset (reset),
      .en_i  (advance),
      .d_i   (memWb_d),
      .q_o   (memWb_q)
   );

   assign {valid_W, regWrite_W, memtoReg_W, rd_W, readData_W, aluResult_W} = memWb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against
// a transaction-level model that tracks how long the instruction in M has
// been there and whether its access has been acknowledged.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_E, memRead_E, memWrite_E, branch_E, regWrite_E, memtoReg_E;
   logic [4:0]  rd_E;
   logic [63:0] aluResult_E, writeData_E, PCBranch_E;
   logic        zero_E, flush_E;
   logic        dm_req, dm_we;
   logic [63:0] dm_addr, dm_wdata, dm_rdata;
   logic        dm_ack;
   logic        stall_M, PCSrc_M;
   logic [63:0] PCBranch_M;
   logic        valid_W, regWrite_W, memtoReg_W;
   logic [4:0]  rd_W;
   logic [63:0] readData_W, aluResult_W;

   int tests = 0;
   int fails = 0;

   mem_stage #(.N(64)) dut (
      .clk         (clk),
      .reset       (reset),
      .valid_E     (valid_E),
      .memRead_E   (memRead_E),
      .memWrite_E  (memWrite_E),
      .branch_E    (branch_E),
      .regWrite_E  (regWrite_E),
      .memtoReg_E  (memtoReg_E),
      .rd_E        (rd_E),
      .aluResult_E (aluResult_E),
      .writeData_E (writeData_E),
      .PCBranch_E  (PCBranch_E),
      .zero_E      (zero_E),
      .flush_E     (flush_E),
      .dm_req      (dm_req),
      .dm_we       (dm_we),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .dm_rdata    (dm_rdata),
      .dm_ack      (dm_ack),
      .stall_M     (stall_M),
      .PCSrc_M     (PCSrc_M),
      .PCBranch_M  (PCBranch_M),
      .valid_W     (valid_W),
      .regWrite_W  (regWrite_W),
      .memtoReg_W  (memtoReg_W),
      .rd_W        (rd_W),
      .readData_W  (readData_W),
      .aluResult_W (aluResult_W)
   );

   always #5 clk = ~clk;

   // Reference model: the instruction currently in M, how many cycles it
   // has spent there, whether its memory access has completed, and what
   // writeback is currently showing
   typedef struct {
      bit        valid, mr, mw, br, rw, m2r, zero;
      bit [4:0]  rd;
      bit [63:0] alu, wd, pcb;
   } instT;

   typedef struct {
      bit        valid, rw, m2r;
      bit [4:0]  rd;
      bit [63:0] readData, alu;
   } wbT;

   instT      mInst = '{default: 0};
   wbT        wOut = '{default: 0};
   int        cycM = 0;
   bit        ackDone = 1'b0;
   bit [63:0] captured = 64'd0;

   function automatic bit memopExp();
      return mInst.valid && (mInst.mr || mInst.mw);
   endfunction

   // Still waiting for the acknowledge: the op is held in M
   function automatic bit stallExp();
      return memopExp() && !ackDone;
   endfunction

   // Request is on from the second cycle in M until acknowledged
   function automatic bit reqExp();
      return memopExp() && (cycM >= 1) && !ackDone;
   endfunction

   task automatic modelReset();
      mInst    = '{default: 0};
      wOut     = '{default: 0};
      cycM     = 0;
      ackDone  = 1'b0;
      captured = 64'd0;
   endtask

   task automatic modelEdge();
      bit adv;
      bit ackNow;
      adv    = !stallExp();
      ackNow = reqExp() && dm_ack;
      if (ackNow) captured = dm_rdata;
      if (adv) begin
         wOut.valid    = mInst.valid;
         wOut.rw       = mInst.rw;
         wOut.m2r      = mInst.m2r;
         wOut.rd       = mInst.rd;
         wOut.alu      = mInst.alu;
         wOut.readData = (mInst.mr && !mInst.mw) ? captured : 64'd0;
         mInst.valid = valid_E && !flush_E;
         mInst.mr    = memRead_E;
         mInst.mw    = memWrite_E;
         mInst.br    = branch_E;
         mInst.rw    = regWrite_E;
         mInst.m2r   = memtoReg_E;
         mInst.zero  = zero_E;
         mInst.rd    = rd_E;
         mInst.alu   = aluResult_E;
         mInst.wd    = writeData_E;
         mInst.pcb   = PCBranch_E;
         cycM    = 0;
         ackDone = 1'b0;
      end else begin
         cycM++;
         if (ackNow) ackDone = 1'b1;
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) modelReset();
      else modelEdge();
   end

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model comparison of every output on every falling edge
   task automatic checkOutput();
      checkVal("dm_req",      dm_req,      reqExp());
      checkVal("dm_we",       dm_we,       mInst.mw);
      checkVal("dm_addr",     dm_addr,     mInst.alu);
      checkVal("dm_wdata",    dm_wdata,    mInst.wd);
      checkVal("stall_M",     stall_M,     stallExp());
      checkVal("PCSrc_M",     PCSrc_M,     mInst.valid && mInst.br && mInst.zero);
      checkVal("PCBranch_M",  PCBranch_M,  mInst.pcb);
      checkVal("valid_W",     valid_W,     wOut.valid);
      checkVal("regWrite_W",  regWrite_W,  wOut.rw);
      checkVal("memtoReg_W",  memtoReg_W,  wOut.m2r);
      checkVal("rd_W",        rd_W,        wOut.rd);
      checkVal("readData_W",  readData_W,  wOut.readData);
      checkVal("aluResult_W", aluResult_W, wOut.alu);
   endtask

   always @(negedge clk) checkOutput();

   // Advance one full cycle; returns just after the falling-edge compare
   task automatic applyStimulus();
      @(negedge clk);
      #1;
   endtask

   task automatic clearInputs();
      valid_E = 0; memRead_E = 0; memWrite_E = 0; branch_E = 0;
      regWrite_E = 0; memtoReg_E = 0; rd_E = 0; zero_E = 0; flush_E = 0;
      aluResult_E = 0; writeData_E = 0; PCBranch_E = 0;
      dm_ack = 0; dm_rdata = 0;
   endtask

   task automatic driveLoad(input logic [63:0] addr, input logic [4:0] rd);
      clearInputs();
      valid_E = 1; memRead_E = 1; regWrite_E = 1; memtoReg_E = 1;
      aluResult_E = addr; rd_E = rd;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int stallCnt, reqCnt, reqPulses, doneCnt;
      bit prevReq;

      reset = 1'b1;
      clearInputs();
      applyStimulus();
      applyStimulus();
      checkVal("reset dm_req",  dm_req,  1'b0);
      checkVal("reset stall",   stall_M, 1'b0);
      checkVal("reset valid_W", valid_W, 1'b0);
      reset = 1'b0;
      applyStimulus();

      // ALU op passes through in one cycle without stalling
      clearInputs();
      valid_E = 1; regWrite_E = 1; aluResult_E = 64'h2A; rd_E = 3;
      applyStimulus();
      checkVal("alu stall", stall_M, 1'b0);
      clearInputs();
      applyStimulus();
      checkVal("alu valid_W", valid_W, 1'b1);
      checkVal("alu aluResult_W", aluResult_W, 64'h2A);
      checkVal("alu rd_W", rd_W, 64'd3);
      applyStimulus();
      checkVal("alu no req", dm_req, 1'b0);

      // Load acknowledged on the third request cycle
      driveLoad(64'h100, 5'd7);
      applyStimulus();
      clearInputs();
      stallCnt = 0; reqCnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (stall_M) stallCnt++;
         if (dm_req) begin
            reqCnt++;
            checkVal("load dm_addr", dm_addr, 64'h100);
            checkVal("load dm_we", dm_we, 1'b0);
         end
         dm_ack   = dm_req && (reqCnt == 3);
         dm_rdata = 64'hDEADBEEF;
         if (!stall_M) break;
         applyStimulus();
      end
      dm_ack = 0;
      checkVal("load stall cycles", stallCnt, 64'd4);
      applyStimulus();
      checkVal("load readData_W", readData_W, 64'hDEADBEEF);
      checkVal("load rd_W", rd_W, 64'd7);

      // Store acknowledged immediately
      clearInputs();
      valid_E = 1; memWrite_E = 1; aluResult_E = 64'h8; writeData_E = 64'h55;
      applyStimulus();
      clearInputs();
      stallCnt = 0; reqCnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (stall_M) stallCnt++;
         if (dm_req) begin
            reqCnt++;
            checkVal("store dm_we", dm_we, 1'b1);
            checkVal("store dm_wdata", dm_wdata, 64'h55);
         end
         dm_ack = dm_req;
         if (!stall_M) break;
         applyStimulus();
      end
      dm_ack = 0;
      checkVal("store cycles in M", stallCnt + 1, 64'd3);
      checkVal("store req cycles", reqCnt, 64'd1);
      applyStimulus();
      checkVal("store readData_W", readData_W, 64'd0);
      checkVal("store valid_W", valid_W, 1'b1);

      // Branch taken, then not taken
      clearInputs();
      valid_E = 1; branch_E = 1; zero_E = 1; PCBranch_E = 64'h40;
      applyStimulus();
      checkVal("branch PCSrc taken", PCSrc_M, 1'b1);
      checkVal("branch PCBranch", PCBranch_M, 64'h40);
      zero_E = 0;
      applyStimulus();
      checkVal("branch PCSrc not taken", PCSrc_M, 1'b0);
      clearInputs();
      applyStimulus();

      // Reset in the middle of a request, then a stray acknowledge
      driveLoad(64'h180, 5'd9);
      applyStimulus();
      clearInputs();
      applyStimulus();
      checkVal("midreq dm_req before reset", dm_req, 1'b1);
      reset = 1'b1;
      #1;
      checkVal("midreq dm_req", dm_req, 1'b0);
      checkVal("midreq stall", stall_M, 1'b0);
      checkVal("midreq valid_W", valid_W, 1'b0);
      applyStimulus();
      reset  = 1'b0;
      dm_ack = 1'b1;
      dm_rdata = 64'h1234;
      applyStimulus();
      checkVal("late ack dm_req", dm_req, 1'b0);
      checkVal("late ack stall", stall_M, 1'b0);
      dm_ack = 1'b0;
      applyStimulus();
      checkVal("late ack readData_W", readData_W, 64'd0);

      // Flushed load becomes a bubble
      driveLoad(64'h1C0, 5'd2);
      flush_E = 1;
      applyStimulus();
      clearInputs();
      checkVal("flush stall", stall_M, 1'b0);
      applyStimulus();
      checkVal("flush valid_W", valid_W, 1'b0);

      // Two back-to-back loads with immediate acknowledge
      driveLoad(64'h200, 5'd1);
      applyStimulus();
      driveLoad(64'h300, 5'd2);
      reqPulses = 0; doneCnt = 0; prevReq = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (dm_req && !prevReq) reqPulses++;
         prevReq = dm_req;
         if (!stall_M) doneCnt++;
         if (c == 3) begin
            checkVal("b2b first readData_W", readData_W, 64'h1111);
            checkVal("b2b first rd_W", rd_W, 64'd1);
            clearInputs();
         end
         dm_ack   = dm_req;
         dm_rdata = (dm_addr == 64'h200) ? 64'h1111 : 64'h2222;
         applyStimulus();
      end
      dm_ack = 0;
      checkVal("b2b req pulses", reqPulses, 64'd2);
      checkVal("b2b done cycles", doneCnt, 64'd2);
      checkVal("b2b second readData_W", readData_W, 64'h2222);
      checkVal("b2b second rd_W", rd_W, 64'd2);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         int kind;
         kind = $urandom_range(0, 3);
         clearInputs();
         reset       = ($urandom_range(0, 99) == 0);
         valid_E     = ($urandom_range(0, 9) != 0);
         flush_E     = ($urandom_range(0, 9) == 0);
         memRead_E   = (kind == 1) || ($urandom_range(0, 7) == 0);
         memWrite_E  = (kind == 2) || ($urandom_range(0, 7) == 0);
         branch_E    = (kind == 3);
         zero_E      = $urandom_range(0, 1);
         regWrite_E  = $urandom_range(0, 1);
         memtoReg_E  = $urandom_range(0, 1);
         rd_E        = 5'($urandom);
         aluResult_E = {32'($urandom), 32'($urandom)};
         writeData_E = {32'($urandom), 32'($urandom)};
         PCBranch_E  = {32'($urandom), 32'($urandom)};
         dm_ack      = ($urandom_range(0, 9) < 4);
         dm_rdata    = {32'($urandom), 32'($urandom)};
         applyStimulus();
      end
      reset = 1'b0;
      clearInputs();
      applyStimulus();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
